// File: rtl/md_sched.sv
// md_sched: E-stage multiply/divide sequencer.
// Issues one MD op at a time, holds HI/LO, raises busy/stall.
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        exc_int,
    input  logic        d_md_use,
    output logic        start,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   pend_hi;
    logic [31:0]   pend_lo;
    logic          pend_wr;

    logic          is_mul;
    logic          is_div;
    logic [31:0]   res_hi;
    logic [31:0]   res_lo;
    logic          res_wr;
    logic [63:0]   prod;
    logic [31:0]   abs_a;
    logic [31:0]   abs_b;
    logic [31:0]   uq;
    logic [31:0]   ur;

    always_comb begin
        is_mul = 1'b0;
        is_div = 1'b0;
        case (md_op)
            4'd1, 4'd2: is_mul = 1'b1;
            4'd3, 4'd4: is_div = 1'b1;
            default: ;
        endcase
    end

    assign start    = (state == IDLE) && (is_mul || is_div) && !exc_int;
    assign stall_md = d_md_use && (start || busy);

    // Signed division runs on magnitudes so the INT_MIN / -1 case wraps cleanly.
    always_comb begin
        prod   = 64'd0;
        abs_a  = op_a;
        abs_b  = op_b;
        uq     = 32'd0;
        ur     = 32'd0;
        res_hi = 32'd0;
        res_lo = 32'd0;
        res_wr = 1'b1;
        case (md_op)
            4'd1: begin
                prod = {{32{op_a[31]}}, op_a} * {{32{op_b[31]}}, op_b};
                {res_hi, res_lo} = prod;
            end
            4'd2: begin
                prod = {32'd0, op_a} * {32'd0, op_b};
                {res_hi, res_lo} = prod;
            end
            4'd3: begin
                abs_a = op_a[31] ? (~op_a + 32'd1) : op_a;
                abs_b = op_b[31] ? (~op_b + 32'd1) : op_b;
                if (op_b == 32'd0) begin
                    res_wr = 1'b0;
                end else begin
                    uq     = abs_a / abs_b;
                    ur     = abs_a % abs_b;
                    res_lo = (op_a[31] ^ op_b[31]) ? (~uq + 32'd1) : uq;
                    res_hi = op_a[31] ? (~ur + 32'd1) : ur;
                end
            end
            4'd4: begin
                if (op_b == 32'd0) begin
                    res_wr = 1'b0;
                end else begin
                    res_lo = op_a / op_b;
                    res_hi = op_a % op_b;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pend_hi <= res_hi;
                        pend_lo <= res_lo;
                        pend_wr <= res_wr;
                        busy    <= 1'b1;
                        if (is_mul) begin
                            cnt   <= CW'(MULT_CYCLES);
                            state <= MUL;
                        end else begin
                            cnt   <= CW'(DIV_CYCLES);
                            state <= DIV;
                        end
                    end else if (!exc_int && md_op == 4'd5) begin
                        hi <= op_a;
                    end else if (!exc_int && md_op == 4'd6) begin
                        lo <= op_a;
                    end
                end
                MUL, DIV: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (pend_wr) begin
                            hi <= pend_hi;
                            lo <= pend_lo;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: directed checks for the MD sequencer.
// Inputs change 1ns after the rising edge; outputs sampled there.
module tb_md_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  md_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        exc_int;
    logic        d_md_use;
    logic        start;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    int vecs = 0;
    int errs = 0;

    md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .md_op(md_op), .op_a(op_a), .op_b(op_b),
        .exc_int(exc_int), .d_md_use(d_md_use), .start(start), .busy(busy),
        .stall_md(stall_md), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // No MD op may be presented while the unit is busy.
    always @(negedge clk) begin
        if (reset && busy && md_op >= 4'd1 && md_op <= 4'd6) begin
            errs++;
            $display("FAIL op_while_busy: md_op=%0d with busy=1", md_op);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, output logic st,
                         output int nbusy);
        md_op = op;
        op_a  = a;
        op_b  = b;
        #1 st = start;
        step();
        md_op = 4'd0;
        nbusy = 0;
        while (busy && nbusy < 40) begin
            nbusy++;
            step();
        end
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        md_op    = 4'd0;
        op_a     = 32'd0;
        op_b     = 32'd0;
        exc_int  = 1'b0;
        d_md_use = 1'b1;
        #2;
        vecs++;
        if ({start, busy, stall_md} !== 3'b000) begin
            errs++;
            $display("FAIL reset_ctl: got %b want 000", {start, busy, stall_md});
        end
        vecs++;
        if ({hi, lo} !== 64'd0) begin
            errs++;
            $display("FAIL reset_hilo: got %h want 0", {hi, lo});
        end
        step();
        reset    = 1'b1;
        d_md_use = 1'b0;
        step();
    endtask

    task automatic test_mult();
        logic st;
        int n;
        issue(4'd1, 32'hFFFF_FFFD, 32'd5, st, n);
        vecs++;
        if (st !== 1'b1) begin
            errs++;
            $display("FAIL mult_start: got %b want 1", st);
        end
        vecs++;
        if (n !== 5) begin
            errs++;
            $display("FAIL mult_busy: got %0d want 5", n);
        end
        vecs++;
        if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFF1) begin
            errs++;
            $display("FAIL mult_hilo: got %h want FFFFFFFFFFFFFFF1", {hi, lo});
        end
    endtask

    task automatic test_div();
        logic st;
        int n;
        issue(4'd4, 32'd7, 32'd2, st, n);
        vecs++;
        if (n !== 10) begin
            errs++;
            $display("FAIL divu_busy: got %0d want 10", n);
        end
        vecs++;
        if ({hi, lo} !== {32'd1, 32'd3}) begin
            errs++;
            $display("FAIL divu_hilo: got %h want 0000000100000003", {hi, lo});
        end
        issue(4'd3, 32'hFFFF_FFF9, 32'd2, st, n);
        vecs++;
        if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            errs++;
            $display("FAIL div_neg: got %h want FFFFFFFFFFFFFFFD", {hi, lo});
        end
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, st, n);
        vecs++;
        if ({hi, lo} !== 64'h0000_0000_8000_0000) begin
            errs++;
            $display("FAIL div_ovf: got %h want 0000000080000000", {hi, lo});
        end
    endtask

    task automatic test_div_zero();
        logic st;
        int n;
        md_op = 4'd5;
        op_a  = 32'h11;
        step();
        md_op = 4'd6;
        op_a  = 32'h22;
        step();
        md_op = 4'd0;
        issue(4'd3, 32'd5, 32'd0, st, n);
        vecs++;
        if (n !== 10) begin
            errs++;
            $display("FAIL div0_busy: got %0d want 10", n);
        end
        vecs++;
        if ({hi, lo} !== {32'h11, 32'h22}) begin
            errs++;
            $display("FAIL div0_hilo: got %h want 0000001100000022", {hi, lo});
        end
    endtask

    task automatic test_mthi();
        md_op   = 4'd5;
        op_a    = 32'hABCD;
        exc_int = 1'b1;
        #1;
        vecs++;
        if (start !== 1'b0) begin
            errs++;
            $display("FAIL mthi_exc_start: got %b want 0", start);
        end
        step();
        exc_int = 1'b0;
        md_op   = 4'd0;
        vecs++;
        if (hi !== 32'h11) begin
            errs++;
            $display("FAIL mthi_exc_hi: got %h want 00000011", hi);
        end
        md_op = 4'd5;
        #1;
        vecs++;
        if (start !== 1'b0) begin
            errs++;
            $display("FAIL mthi_start: got %b want 0", start);
        end
        step();
        md_op = 4'd0;
        vecs++;
        if ({hi, busy} !== {32'hABCD, 1'b0}) begin
            errs++;
            $display("FAIL mthi_hi: got %h/%b want 0000abcd/0", hi, busy);
        end
    endtask

    task automatic test_exc();
        int n;
        md_op   = 4'd1;
        op_a    = 32'd6;
        op_b    = 32'd7;
        exc_int = 1'b1;
        #1;
        vecs++;
        if (start !== 1'b0) begin
            errs++;
            $display("FAIL exc_start: got %b want 0", start);
        end
        step();
        md_op   = 4'd0;
        exc_int = 1'b0;
        vecs++;
        if ({busy, hi, lo} !== {1'b0, 32'hABCD, 32'h22}) begin
            errs++;
            $display("FAIL exc_nochange: got %b/%h/%h", busy, hi, lo);
        end
        md_op = 4'd1;
        step();
        md_op   = 4'd0;
        exc_int = 1'b1;
        n = 0;
        while (busy && n < 40) begin
            n++;
            step();
        end
        exc_int = 1'b0;
        vecs++;
        if (n !== 5 || {hi, lo} !== {32'd0, 32'd42}) begin
            errs++;
            $display("FAIL exc_busy: got %0d/%h want 5/000000000000002a", n, {hi, lo});
        end
    endtask

    task automatic test_stall();
        int n;
        int bad;
        d_md_use = 1'b1;
        #1;
        vecs++;
        if (stall_md !== 1'b0) begin
            errs++;
            $display("FAIL stall_idle: got %b want 0", stall_md);
        end
        md_op = 4'd3;
        op_a  = 32'd9;
        op_b  = 32'd3;
        #1;
        vecs++;
        if (stall_md !== 1'b1) begin
            errs++;
            $display("FAIL stall_start: got %b want 1", stall_md);
        end
        step();
        md_op = 4'd0;
        n     = 0;
        bad   = 0;
        while (busy && n < 40) begin
            if (stall_md !== 1'b1) bad++;
            n++;
            step();
        end
        vecs++;
        if (bad !== 0 || n !== 10) begin
            errs++;
            $display("FAIL stall_busy: got %0d low of %0d want 0 of 10", bad, n);
        end
        vecs++;
        if (stall_md !== 1'b0) begin
            errs++;
            $display("FAIL stall_after: got %b want 0", stall_md);
        end
        d_md_use = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic st;
        int n;
        md_op = 4'd2;
        op_a  = 32'hFFFF_FFFF;
        op_b  = 32'd2;
        step();
        md_op = 4'd0;
        step();
        step();
        reset = 1'b0;
        #1;
        vecs++;
        if ({busy, hi, lo} !== 65'd0) begin
            errs++;
            $display("FAIL reset_mid: got %b/%h/%h want 0/0/0", busy, hi, lo);
        end
        step();
        reset = 1'b1;
        step();
        vecs++;
        if ({busy, hi, lo} !== 65'd0) begin
            errs++;
            $display("FAIL reset_discard: got %b/%h/%h want 0/0/0", busy, hi, lo);
        end
        issue(4'd2, 32'hFFFF_FFFF, 32'd2, st, n);
        vecs++;
        if (n !== 5 || {hi, lo} !== 64'h0000_0001_FFFF_FFFE) begin
            errs++;
            $display("FAIL multu_reissue: got %0d/%h want 5/00000001fffffffe", n, {hi, lo});
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_mthi();
        test_exc();
        test_stall();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
